// File: rtl/relu_conv_2d_mul_arbiter.sv
// Round-robin arbiter that shares one signed multiplier among NUM_REQ requesters.
// The truncated product and the requester ID go into a one-deep output register with valid/ready.
module relu_conv_2d_mul_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned din0_WIDTH = 32,
  parameter int unsigned din1_WIDTH = 32,
  parameter int unsigned dout_WIDTH = 48
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*din0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*din1_WIDTH-1:0]    req_din1,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ID_WIDTH-1:0]              out_id,
  output logic [dout_WIDTH-1:0]            out_dout
);

  localparam int unsigned PW = din0_WIDTH + din1_WIDTH;

  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic                  found;
  logic                  accept;
  logic                  hs;
  logic [din0_WIDTH-1:0] op0;
  logic [din1_WIDTH-1:0] op1;
  logic [PW-1:0]         op0_ext;
  logic [PW-1:0]         op1_ext;
  logic [PW-1:0]         prod;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : grant_scan
    int unsigned         idx;
    logic [ID_WIDTH-1:0] idx_n;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    idx_n   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx   = (32'(rr_ptr) + k) % NUM_REQ;
      idx_n = idx[ID_WIDTH-1:0];
      if (!found && req_valid[idx_n]) begin
        found   = 1'b1;
        gnt_idx = idx_n;
      end
    end
  end

  always_comb begin
    op0 = '0;
    op1 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == i[ID_WIDTH-1:0]) begin
        op0 = req_din0[i*din0_WIDTH +: din0_WIDTH];
        op1 = req_din1[i*din1_WIDTH +: din1_WIDTH];
      end
    end
  end

  // Sign-extending both operands to the full product width lets an unsigned
  // multiply yield the exact two's-complement product bits.
  assign op0_ext = {{din1_WIDTH{op0[din0_WIDTH-1]}}, op0};
  assign op1_ext = {{din0_WIDTH{op1[din1_WIDTH-1]}}, op1};
  assign prod    = op0_ext * op1_ext;

  assign accept   = !out_valid || out_ready;
  assign hs       = ap_rst_n && accept && found;
  assign next_ptr = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_dout  <= '0;
    end else if (hs) begin
      out_dout  <= prod[dout_WIDTH-1:0];
      out_id    <= gnt_idx;
      out_valid <= 1'b1;
      rr_ptr    <= next_ptr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu_conv_2d_mul_arbiter.sv
// Self-checking bench for relu_conv_2d_mul_arbiter: a scoreboard queue of expected results
// plus per-scenario tasks. A second instance with NUM_REQ=3 covers the non-power-of-two wrap.
module tb_relu_conv_2d_mul_arbiter;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_din0;
  logic [127:0] req_din1;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_id;
  logic [47:0]  out_dout;
  logic [31:0]  op0 [4];
  logic [31:0]  op1 [4];

  logic [2:0]   v3;
  logic [2:0]   r3;
  logic [95:0]  a3;
  logic [95:0]  b3;
  logic         ov3;
  logic         or3;
  logic [1:0]   id3;
  logic [47:0]  d3;

  int checks = 0;
  int failures = 0;

  always #5 ap_clk = ~ap_clk;

  assign req_din0 = {op0[3], op0[2], op0[1], op0[0]};
  assign req_din1 = {op1[3], op1[2], op1[1], op1[0]};

  relu_conv_2d_mul_arbiter #(
    .NUM_REQ(4), .ID_WIDTH(2), .din0_WIDTH(32), .din1_WIDTH(32), .dout_WIDTH(48)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_dout(out_dout)
  );

  relu_conv_2d_mul_arbiter #(
    .NUM_REQ(3), .ID_WIDTH(2), .din0_WIDTH(32), .din1_WIDTH(32), .dout_WIDTH(48)
  ) dut3 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(v3), .req_ready(r3),
    .req_din0(a3), .req_din1(b3),
    .out_valid(ov3), .out_ready(or3),
    .out_id(id3), .out_dout(d3)
  );

  function automatic logic [47:0] mulm(input logic [31:0] a, input logic [31:0] b);
    longint pa, pb, p;
    pa = $signed(a);
    pb = $signed(b);
    p  = pa * pb;
    return p[47:0];
  endfunction

  typedef struct packed {
    logic [1:0]  id;
    logic [47:0] d;
  } exp_t;

  exp_t       sbq[$];
  exp_t       sb_new;
  logic [1:0] m_ptr = '0;
  logic       m_valid = 1'b0;
  bit         sb_hs = 0;
  bit         sb_cons = 0;
  bit         mf;
  int         mg;
  logic [3:0] exp_ready;

  // Reference arbiter evaluated mid-cycle; results are pushed at the grant edge and popped on drain.
  always @(negedge ap_clk) begin
    sb_hs   = 0;
    sb_cons = 0;
    if (!ap_rst_n) begin
      checks++;
      if (req_ready !== 4'b0) begin
        failures++;
        $display("FAIL sb_rst_ready got=%b exp=0000", req_ready);
      end
    end else begin
      mf = 0;
      mg = 0;
      for (int k = 0; k < 4; k++) begin
        if (!mf && req_valid[(int'(m_ptr) + k) % 4]) begin
          mf = 1;
          mg = (int'(m_ptr) + k) % 4;
        end
      end
      exp_ready = ((!m_valid || out_ready) && mf) ? (4'b0001 << mg) : 4'b0000;
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL sb_ready got=%b exp=%b", req_ready, exp_ready);
      end
      checks++;
      if (out_valid !== m_valid) begin
        failures++;
        $display("FAIL sb_out_valid got=%b exp=%b", out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL sb_empty got=empty exp=entry");
        end else if (out_id !== sbq[0].id || out_dout !== sbq[0].d) begin
          failures++;
          $display("FAIL sb_result got=id%0d/%h exp=id%0d/%h",
                   out_id, out_dout, sbq[0].id, sbq[0].d);
        end
      end
      sb_hs     = (!m_valid || out_ready) && mf;
      sb_cons   = m_valid && out_ready;
      sb_new.id = 2'(mg);
      sb_new.d  = mulm(op0[mg], op1[mg]);
    end
  end

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_ptr   = '0;
      m_valid = 1'b0;
      sbq.delete();
      sb_hs   = 0;
      sb_cons = 0;
    end else begin
      if (sb_cons && sbq.size() > 0) void'(sbq.pop_front());
      if (sb_hs) begin
        sbq.push_back(sb_new);
        m_ptr = (sb_new.id == 2'd3) ? 2'd0 : sb_new.id + 2'd1;
      end
      m_valid = sb_hs ? 1'b1 : (sb_cons ? 1'b0 : m_valid);
      sb_hs   = 0;
      sb_cons = 0;
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      op0[i] = $urandom;
      op1[i] = $urandom;
    end
  endtask

  task automatic do_reset();
    ap_rst_n  = 1'b0;
    req_valid = 4'b0;
    out_ready = 1'b1;
    v3        = 3'b0;
    tick();
    tick();
    ap_rst_n  = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    out_ready = 1'b1;
    rand_ops();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_id !== 2'd0 || out_dout !== 48'd0 || req_ready !== 4'b0) begin
      failures++;
      $display("FAIL reset_state got=v%b id%0d d%h r%b exp=all zero", out_valid, out_id, out_dout, req_ready);
    end
    tick();
    tick();
    ap_rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant got=%b exp=0001", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_first_id got=v%b id%0d exp=v1 id0", out_valid, out_id);
    end
  endtask

  task automatic test_round_robin();
    int exp_all[6] = '{0, 1, 2, 3, 0, 1};
    int exp_odd[4] = '{1, 3, 1, 3};
    do_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      rand_ops();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'(exp_all[k])) begin
        failures++;
        $display("FAIL rr_all[%0d] got=v%b id%0d exp=v1 id%0d", k, out_valid, out_id, exp_all[k]);
      end
    end
    do_reset();
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      rand_ops();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'(exp_odd[k])) begin
        failures++;
        $display("FAIL rr_odd[%0d] got=v%b id%0d exp=v1 id%0d", k, out_valid, out_id, exp_odd[k]);
      end
    end
  endtask

  task automatic test_arith();
    logic [31:0] a_t[4] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00001000};
    logic [31:0] b_t[4] = '{32'h7FFFFFFF, 32'h00000005, 32'h80000000, 32'hFFFFF000};
    logic [47:0] p_t[4] = '{48'hFFFF00000001, 48'hFFFFFFFFFFFB, 48'h000000000000, 48'hFFFFFF000000};
    do_reset();
    rand_ops();
    req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      op0[2] = a_t[k];
      op1[2] = b_t[k];
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd2 || out_dout !== p_t[k]) begin
        failures++;
        $display("FAIL arith[%0d] got=v%b id%0d %h exp=v1 id2 %h", k, out_valid, out_id, out_dout, p_t[k]);
      end
    end
    req_valid = 4'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [47:0] held;
    do_reset();
    req_valid = 4'hF;
    rand_ops();
    held = mulm(op0[0], op1[0]);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      #1;
      checks++;
      if (req_ready !== 4'b0) begin
        failures++;
        $display("FAIL bp_ready[%0d] got=%b exp=0000", k, req_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd0 || out_dout !== held) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=v%b id%0d %h exp=v1 id0 %h", k, out_valid, out_id, out_dout, held);
      end
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      rand_ops();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'(k)) begin
        failures++;
        $display("FAIL bp_drain[%0d] got=v%b id%0d exp=v1 id%0d", k, out_valid, out_id, k);
      end
    end
  endtask

  task automatic test_midstream_reset();
    for (int i = 0; i < 4; i++) begin
      op0[i] = 32'd3;
      op1[i] = 32'd7;
    end
    req_valid = 4'hF;
    out_ready = 1'b1;
    tick();
    tick();
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_id !== 2'd0 || out_dout !== 48'd0 || req_ready !== 4'b0) begin
      failures++;
      $display("FAIL mid_reset got=v%b id%0d d%h r%b exp=all zero", out_valid, out_id, out_dout, req_ready);
    end
    tick();
    ap_rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL mid_reset_grant got=%b exp=0001", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || out_dout !== 48'd21) begin
      failures++;
      $display("FAIL mid_reset_result got=v%b id%0d %h exp=v1 id0 15", out_valid, out_id, out_dout);
    end
  endtask

  task automatic test_npot();
    int exp3[7] = '{0, 1, 2, 0, 1, 2, 0};
    do_reset();
    req_valid = 4'b0;
    or3 = 1'b1;
    v3  = 3'b111;
    for (int k = 0; k < 7; k++) begin
      a3 = {$urandom, $urandom, $urandom};
      b3 = {$urandom, $urandom, $urandom};
      tick();
      checks++;
      if (ov3 !== 1'b1 || id3 !== 2'(exp3[k])) begin
        failures++;
        $display("FAIL npot[%0d] got=v%b id%0d exp=v1 id%0d", k, ov3, id3, exp3[k]);
      end
    end
    v3 = 3'b0;
  endtask

  task automatic test_stress();
    int  wc[4];
    int  worst;
    bit  hs_any;
    do_reset();
    for (int i = 0; i < 4; i++) wc[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      req_valid = 4'($urandom) | 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      rand_ops();
      #1;
      hs_any = |(req_valid & req_ready);
      worst  = 0;
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] || req_ready[i]) wc[i] = 0;
        else if (hs_any) wc[i]++;
        if (wc[i] > worst) worst = wc[i];
      end
      checks++;
      if (worst >= 4) begin
        failures++;
        $display("FAIL starve[%0d] got=%0d waits exp<4", cyc, worst);
      end
      tick();
    end
    req_valid = 4'b0;
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || sbq.size() != 0) begin
      failures++;
      $display("FAIL stress_drain got=v%b q%0d exp=v0 q0", out_valid, sbq.size());
    end
  endtask

  initial begin
    req_valid = 4'b0;
    out_ready = 1'b1;
    v3  = 3'b0;
    or3 = 1'b1;
    a3  = '0;
    b3  = '0;
    rand_ops();
    test_reset();
    test_round_robin();
    test_arith();
    test_backpressure();
    test_midstream_reset();
    test_npot();
    test_stress();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/relu_conv_2d_mul_arbiter.md
# relu_conv_2d_mul_arbiter

Round-robin arbiter that shares one signed din0_WIDTH x din1_WIDTH multiplier among NUM_REQ requesters in the relu_conv_2d accelerator. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, multiplies, and registers the truncated product with the requester ID into a one-deep output stage with valid/ready backpressure. It sits between the convolution lanes and the shared multiplier resource, replacing one multiplier per lane.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- ID_WIDTH, 2: width of out_id; must equal clog2(NUM_REQ).
- din0_WIDTH, 32: operand A width, signed.
- din1_WIDTH, 32: operand B width, signed.
- dout_WIDTH, 48: product width; low bits of the full signed product.

- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  bit i: requester i presents operands.
- req_ready  out  NUM_REQ  bit i: requester i granted this cycle; at most one bit set.
- req_din0  in  NUM_REQ*din0_WIDTH  requester i operand A at [i*din0_WIDTH +: din0_WIDTH].
- req_din1  in  NUM_REQ*din1_WIDTH  requester i operand B at [i*din1_WIDTH +: din1_WIDTH].
- out_valid  out  1  output register holds a result.
- out_ready  in  1  consumer accepts the result.
- out_id  out  ID_WIDTH  index of the requester that produced out_dout.
- out_dout  out  dout_WIDTH  registered product.

## Operation
- State: rr_ptr (ID_WIDTH), out_valid, out_id, out_dout. All reset to 0 asynchronously on ap_rst_n low.
- req_ready is forced to 0 while ap_rst_n is low.
- accept = !out_valid || out_ready. The output stage is free or is draining this cycle.
- Grant selection is combinational.
  - g is the first index i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
  - req_ready[g]=1 only when accept=1 and some req_valid bit is set. Otherwise req_ready is all zero.
- Handshake on requester g (req_valid[g] && req_ready[g]) at the clock edge:
  - out_dout <= low dout_WIDTH bits of $signed(din0_g) * $signed(din1_g). The full product is din0_WIDTH+din1_WIDTH bits. Truncation is two's complement with no saturation or rounding.
  - out_id <= g; out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ. The wrap is explicit, since NUM_REQ need not be a power of two.
- No handshake with out_valid && out_ready: out_valid <= 0. out_id and out_dout keep their old values.
- No handshake with out_valid && !out_ready: all outputs are held stable and rr_ptr is unchanged.
- No valid requests: rr_ptr is unchanged.
- Requesters must not make req_valid depend on req_ready. req_valid may be deasserted without a grant; the arbiter keeps no memory of withdrawn requests.
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ handshakes.
- Reset mid-operation: any pending result is discarded, out_valid drops immediately, and rr_ptr returns to 0.

## Timing
- Latency: a handshake at edge k makes the result visible with out_valid=1 after edge k, i.e. 1 cycle.
- Throughput: one result per cycle while out_ready=1 and any requester is valid.
- Simultaneous drain and accept: with out_valid=1, out_ready=1 and a valid request, the new result replaces the old one at the same edge, so there is no bubble.
- Backpressure: with out_ready=0 and out_valid=1, req_ready is all zero in the same cycle.
- The combinational path from req_din to the multiplier to the out_dout register is a single cycle. No multicycle or false paths are allowed.

## Test plan
- Reset:
  - Assert ap_rst_n=0 mid-stream with out_valid=1 -> out_valid, out_id and out_dout read 0 immediately, and req_ready=0.
  - After release, all requesters valid -> requester 0 is granted first.
- Round-robin:
  - All 4 requesters valid every cycle, out_ready=1 -> out_id sequence 0,1,2,3,0,1.
  - Only requesters 1 and 3 valid -> 1,3,1,3.
- Arithmetic:
  - 0x7FFFFFFF*0x7FFFFFFF -> 0xFFFF00000001.
  - 0xFFFFFFFF*0x00000005 -> 0xFFFFFFFFFFFB.
  - 0x80000000*0x80000000 -> 0x000000000000.
  - 0x00001000*0xFFFFF000 -> 0xFFFFFF000000.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with requesters valid -> out_id and out_dout stable, req_ready=0 throughout, no result lost or duplicated.
  - Release -> pending results drain in round-robin order.
- Non-power-of-two:
  - NUM_REQ=3, ID_WIDTH=2, all valid -> out_id sequence 0,1,2,0; rr_ptr never reaches 3.
- Random stress:
  - Random req_valid, out_ready and operands over 10k cycles; scoreboard per requester ID -> every handshake yields exactly one correct product.
  - Starvation check -> no requester continuously valid goes more than NUM_REQ handshakes without a grant.
